// File: rtl/msg_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : msg_pingpong_buffer_if
// Brief    : Producer/reader bundle for the double-buffered message store.
// Revision : 1.0 - initial release
// ============================================================================
interface msg_pingpong_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              wr_rq;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_rdy;
    logic              wr_commit;
    logic [ADDR_W-1:0] wr_len;
    logic              rd_rq;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_rdy;
    logic [DATA_W-1:0] data_o;
    logic              rd_release;
    logic              msg_valid;
    logic [ADDR_W-1:0] msg_len;
    logic [DATA_W-1:0] msg_sum;
    logic              overrun;

    modport master (
        output wr_rq, wr_addr, wr_data, wr_commit, wr_len,
        output rd_rq, rd_addr, rd_release,
        input  wr_rdy, rd_rdy, data_o, msg_valid, msg_len, msg_sum, overrun
    );

    modport slave (
        input  wr_rq, wr_addr, wr_data, wr_commit, wr_len,
        input  rd_rq, rd_addr, rd_release,
        output wr_rdy, rd_rdy, data_o, msg_valid, msg_len, msg_sum, overrun
    );
endinterface
`default_nettype wire

// File: rtl/msg_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : msg_pingpong_buffer
// Brief    : Two-bank message store; producer fills one bank while the coder
//            drains the other. MSG_BUF_CHECKSUM_EN enables the XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
module msg_pingpong_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  wire logic            clk,
    input  wire logic            rst_l,
    msg_pingpong_buffer_if.slave bus
);
    localparam int         c_IDX_W     = $clog2(DEPTH);
    localparam logic [1:0] c_WAIT_LAST = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

    typedef enum logic [0:0] {WR_IDLE = 1'b0, WR_ACK = 1'b1} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_WAIT = 2'd1, RD_ACK = 2'd2} rd_state_t;

    wr_state_t         r_wr_state, w_wr_state_nxt;
    rd_state_t         r_rd_state, w_rd_state_nxt;

    logic [DATA_W-1:0] r_mem [2*DEPTH];
    logic              r_bank_sel;
    logic              r_msg_valid;
    logic              r_pending;
    logic              r_overrun;
    logic [ADDR_W-1:0] r_msg_len;
    logic [ADDR_W-1:0] r_pend_len;
    logic [1:0]        r_rd_cnt;
    logic [DATA_W-1:0] r_rd_q;
    logic [DATA_W-1:0] r_data_o;

    logic              w_wr_in_range, w_rd_in_range;
    logic              w_wr_accept, w_rd_accept;
    logic              w_wr_rdy, w_rd_rdy, w_rd_load;
    logic              w_commit_swap, w_commit_pend, w_overrun;
    logic              w_release_swap, w_release_clear, w_swap;
    logic [DATA_W-1:0] w_rd_mem;

    generate
        if (ADDR_W > c_IDX_W) begin : g_addr_check
            assign w_wr_in_range = (bus.wr_addr[ADDR_W-1:c_IDX_W] == '0);
            assign w_rd_in_range = (bus.rd_addr[ADDR_W-1:c_IDX_W] == '0);
        end else begin : g_addr_full
            assign w_wr_in_range = 1'b1;
            assign w_rd_in_range = 1'b1;
        end
    endgenerate

    // Writes stall while a second message waits for the reader to release.
    assign w_wr_accept = (r_wr_state == WR_IDLE) && bus.wr_rq && !r_pending;
    assign w_rd_accept = (r_rd_state == RD_IDLE) && bus.rd_rq;

    always_ff @(posedge clk) begin
        if (rst_l && w_wr_accept && w_wr_in_range)
            r_mem[{r_bank_sel, bus.wr_addr[c_IDX_W-1:0]}] <= bus.wr_data;
    end

    assign w_rd_mem = w_rd_in_range ? r_mem[{~r_bank_sel, bus.rd_addr[c_IDX_W-1:0]}] : '0;

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_wr_state <= WR_IDLE;
        else        r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_rdy       = 1'b0;
        case (r_wr_state)
            WR_IDLE: if (w_wr_accept) w_wr_state_nxt = WR_ACK;
            WR_ACK: begin
                w_wr_rdy       = 1'b1;
                w_wr_state_nxt = WR_IDLE;
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_rd_state <= RD_IDLE;
        else        r_rd_state <= w_rd_state_nxt;
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_rdy       = 1'b0;
        w_rd_load      = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_rd_accept) begin
                    if (RD_LAT == 1) begin
                        w_rd_state_nxt = RD_ACK;
                        w_rd_load      = 1'b1;
                    end else begin
                        w_rd_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (r_rd_cnt == c_WAIT_LAST) begin
                    w_rd_state_nxt = RD_ACK;
                    w_rd_load      = 1'b1;
                end
            end
            RD_ACK: begin
                w_rd_rdy       = 1'b1;
                w_rd_state_nxt = RD_IDLE;
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Data is captured at request time so a swap mid-read cannot change it.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rd_cnt <= '0;
            r_rd_q   <= '0;
            r_data_o <= '0;
        end else begin
            if (w_rd_accept) begin
                r_rd_cnt <= '0;
                r_rd_q   <= w_rd_mem;
            end else if (r_rd_state == RD_WAIT) begin
                r_rd_cnt <= r_rd_cnt + 2'd1;
            end
            if (w_rd_load)
                r_data_o <= (r_rd_state == RD_IDLE) ? w_rd_mem : r_rd_q;
        end
    end

    // ---------------- commit / release ----------------
    assign w_commit_swap   = bus.wr_commit && (!r_msg_valid || (!r_pending && bus.rd_release));
    assign w_commit_pend   = bus.wr_commit && r_msg_valid && !r_pending && !bus.rd_release;
    assign w_overrun       = bus.wr_commit && r_pending;
    assign w_release_swap  = bus.rd_release && r_msg_valid && r_pending;
    assign w_release_clear = bus.rd_release && r_msg_valid && !r_pending && !bus.wr_commit;
    assign w_swap          = w_commit_swap || w_release_swap;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_bank_sel  <= 1'b0;
            r_msg_valid <= 1'b0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_msg_len   <= '0;
            r_pend_len  <= '0;
        end else begin
            r_overrun <= w_overrun;
            if (w_swap) begin
                r_bank_sel  <= ~r_bank_sel;
                r_msg_valid <= 1'b1;
                r_msg_len   <= w_commit_swap ? bus.wr_len : r_pend_len;
            end else if (w_release_clear) begin
                r_msg_valid <= 1'b0;
            end
            if (w_commit_pend) begin
                r_pending  <= 1'b1;
                r_pend_len <= bus.wr_len;
            end else if (w_release_swap) begin
                r_pending  <= 1'b0;
            end
        end
    end

`ifdef MSG_BUF_CHECKSUM_EN
    logic [DATA_W-1:0] r_fill_sum;
    logic [DATA_W-1:0] r_msg_sum;
    logic [DATA_W-1:0] w_fill_sum_upd;

    // A write landing with the commit still belongs to the committed message.
    assign w_fill_sum_upd = (w_wr_accept && w_wr_in_range) ? (r_fill_sum ^ bus.wr_data) : r_fill_sum;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_fill_sum <= '0;
            r_msg_sum  <= '0;
        end else if (w_swap) begin
            r_msg_sum  <= w_fill_sum_upd;
            r_fill_sum <= '0;
        end else begin
            r_fill_sum <= w_fill_sum_upd;
        end
    end

    assign bus.msg_sum = r_msg_sum;
`else
    assign bus.msg_sum = '0;
`endif

    assign bus.wr_rdy    = w_wr_rdy;
    assign bus.rd_rdy    = w_rd_rdy;
    assign bus.data_o    = r_data_o;
    assign bus.msg_valid = r_msg_valid;
    assign bus.msg_len   = r_msg_len;
    assign bus.overrun   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_msg_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_pingpong_buffer
// Brief    : Scoreboard bench for msg_pingpong_buffer (RD_LAT=3, DEPTH=256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_pingpong_buffer;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;
    localparam int RD_LAT = 3;
`ifdef MSG_BUF_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    msg_pingpong_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    msg_pingpong_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model
    logic              m_bank, m_valid, m_pending;
    logic [ADDR_W-1:0] m_len, m_pend_len;
    logic [DATA_W-1:0] m_fill_sum, m_sum;
    logic [DATA_W-1:0] m_mem [2][DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_bank = 1'b0; m_valid = 1'b0; m_pending = 1'b0;
        m_len = '0; m_pend_len = '0; m_fill_sum = '0; m_sum = '0;
        exp_q.delete();
    endtask

    task automatic model_swap(input logic [ADDR_W-1:0] len);
        m_bank     = ~m_bank;
        m_len      = len;
        m_sum      = m_fill_sum;
        m_fill_sum = '0;
        m_valid    = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, ".msg_valid"}, 32'(bus.msg_valid), 32'(m_valid));
        check_eq({tag, ".msg_len"},   32'(bus.msg_len),   32'(m_len));
        check_eq({tag, ".msg_sum"},   32'(bus.msg_sum),   CHK_EN ? 32'(m_sum) : 32'd0);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        int n = 0;
        bus.wr_rq = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        do begin step(); n++; end while (!bus.wr_rdy && n < 8);
        check_eq("wr_ack", 32'(bus.wr_rdy), 32'd1);
        check_eq("wr_lat", 32'(n), 32'd1);
        bus.wr_rq = 1'b0;
        if (addr < DEPTH) begin
            m_mem[m_bank][addr] = data;
            m_fill_sum ^= data;
        end
        step();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr);
        int n = 0;
        logic [DATA_W-1:0] exp;
        bus.rd_rq = 1'b1; bus.rd_addr = addr;
        exp_q.push_back((addr < DEPTH) ? m_mem[~m_bank][addr] : '0);
        do begin step(); n++; end while (!bus.rd_rdy && n < 12);
        check_eq("rd_ack", 32'(bus.rd_rdy), 32'd1);
        check_eq("rd_lat", 32'(n), 32'(RD_LAT));
        exp = exp_q.pop_front();
        check_eq("rd_data", 32'(bus.data_o), 32'(exp));
        bus.rd_rq = 1'b0;
        step();
    endtask

    task automatic do_pulse(input bit commit, input bit release_, input logic [ADDR_W-1:0] len);
        bit v0 = m_valid;
        bit p0 = m_pending;
        bit ov = 1'b0;
        bus.wr_commit = commit; bus.rd_release = release_; bus.wr_len = len;
        step();
        bus.wr_commit = 1'b0; bus.rd_release = 1'b0;
        if (commit) begin
            if (p0)                   ov = 1'b1;
            else if (!v0 || release_) model_swap(len);
            else begin m_pending = 1'b1; m_pend_len = len; end
        end
        if (release_ && v0) begin
            if (p0) begin model_swap(m_pend_len); m_pending = 1'b0; end
            else if (!commit) m_valid = 1'b0;
        end
        check_status("pulse");
        check_eq("overrun", 32'(bus.overrun), 32'(ov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.wr_rq = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_commit = 0; bus.wr_len = '0;
        bus.rd_rq = 0; bus.rd_addr = '0; bus.rd_release = 0;
        model_reset();
        repeat (3) step();
        check_eq("rst.wr_rdy",  32'(bus.wr_rdy),  32'd0);
        check_eq("rst.rd_rdy",  32'(bus.rd_rdy),  32'd0);
        check_eq("rst.data_o",  32'(bus.data_o),  32'd0);
        check_eq("rst.overrun", 32'(bus.overrun), 32'd0);
        check_status("rst");
        rst_l = 1'b1;
        step();

        // Basic message
        do_write(16'd0, 8'h11); do_write(16'd1, 8'h22); do_write(16'd2, 8'h33);
        do_pulse(1'b1, 1'b0, 16'd3);
        do_read(16'd0); do_read(16'd1); do_read(16'd2);

        // Second message while first unreleased; includes an out-of-range write
        do_write(16'd0, 8'h44); do_write(16'h0100, 8'hEE); do_write(16'd1, 8'h55);
        do_pulse(1'b1, 1'b0, 16'd5);
        bus.wr_rq = 1'b1; bus.wr_addr = 16'd3; bus.wr_data = 8'h77;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("stall.no_rdy", 32'(bus.wr_rdy), 32'd0);
        end
        do_pulse(1'b1, 1'b0, 16'd9);
        step();
        check_eq("overrun.one_cycle", 32'(bus.overrun), 32'd0);
        check_eq("stall.still", 32'(bus.wr_rdy), 32'd0);

        // Release swaps in the pending message; stalled write then lands
        bus.rd_release = 1'b1;
        step();
        bus.rd_release = 1'b0;
        model_swap(m_pend_len);
        m_pending = 1'b0;
        check_status("release");
        check_eq("release.no_rdy_yet", 32'(bus.wr_rdy), 32'd0);
        step();
        check_eq("stall.ack", 32'(bus.wr_rdy), 32'd1);
        bus.wr_rq = 1'b0;
        m_mem[m_bank][3] = 8'h77;
        m_fill_sum ^= 8'h77;
        step();
        do_read(16'd0); do_read(16'd1); do_read(16'h0100);

        // Simultaneous commit and release
        do_write(16'd0, 8'h99);
        do_pulse(1'b1, 1'b1, 16'd7);
        do_read(16'd3); do_read(16'd0);

        // Release empties the drain bank; a second release is ignored
        do_pulse(1'b0, 1'b1, 16'd0);
        do_pulse(1'b0, 1'b1, 16'd0);

        // Reset in the middle of a read
        bus.rd_rq = 1'b1; bus.rd_addr = 16'd0;
        step(); step();
        rst_l = 1'b0; bus.rd_rq = 1'b0;
        model_reset();
        #1;
        check_eq("midrst.data_o",  32'(bus.data_o),  32'd0);
        check_eq("midrst.overrun", 32'(bus.overrun), 32'd0);
        check_eq("midrst.wr_rdy",  32'(bus.wr_rdy),  32'd0);
        check_status("midrst");
        for (int i = 0; i < RD_LAT + 1; i++) begin
            step();
            check_eq("midrst.no_rd_rdy", 32'(bus.rd_rdy), 32'd0);
        end
        rst_l = 1'b1;
        step();
        do_write(16'd2, 8'hC3);
        do_pulse(1'b1, 1'b0, 16'd1);
        do_read(16'd2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/msg_pingpong_buffer.md
# msg_pingpong_buffer

Parametrised double-buffered message store that supersedes the single-bank slave device feeding the high-speed protocol transmitter. One bank is filled by a producer through a request/ready write port while the other is drained by the coder through the request/ready read port (TX_RAM_REQ_RD / TX_RAM_RDY_RD / TX_RAM_ADDR_OUT / TX_RAM_DATA_IN). Banks swap on message commit, with back-pressure when the reader has not yet released the previous message.

## Interface
- DATA_W, 8: data width.
- ADDR_W, 16: address bus width; matches the protocol block's RAM address bus.
- DEPTH, 256: words per bank; a power of 2, ≤ 2^ADDR_W.
- RD_LAT, 1: cycles from sampled rd_rq to rd_rdy; 1..4.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_l  in  1  asynchronous, active-low reset.
- wr_rq  in  1  write request; level held until wr_rdy.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_rdy  out  1  one-cycle write acknowledge.
- wr_commit  in  1  one-cycle pulse: the fill bank holds a complete message.
- wr_len  in  ADDR_W  byte count, sampled with wr_commit.
- rd_rq  in  1  read request; level held until rd_rdy.
- rd_addr  in  ADDR_W  read address.
- rd_rdy  out  1  one-cycle read acknowledge.
- data_o  out  DATA_W  read data; valid with rd_rdy, held until the next rd_rdy.
- rd_release  in  1  one-cycle pulse: the reader has finished the drain bank.
- msg_valid  out  1  the drain bank holds an unreleased message.
- msg_len  out  ADDR_W  length of the drain-bank message.
- msg_sum  out  DATA_W  XOR checksum of the drain-bank message (see Configuration).
- overrun  out  1  one-cycle pulse: commit rejected.

## Operation
- State: bank_sel (fill bank = bank_sel, drain bank = !bank_sel), msg_valid, pending, fill_sum, write FSM, read FSM.
- Write FSM, IDLE/ACK:
  - IDLE: wr_rq=1 and pending=0 → write memory, go to ACK.
  - ACK: wr_rdy=1, return to IDLE. wr_rq is ignored in ACK; the producer must drop it.
- Read FSM, IDLE/WAIT(n)/ACK: the drain bank is read at the address sampled in IDLE, and rd_rdy asserts RD_LAT cycles later. Reads are served whatever the value of msg_valid.
- Addresses are truncated to log2(DEPTH) bits for indexing. If any upper bit is set:
  - the write is dropped but still acknowledged, and fill_sum is unchanged;
  - the read returns 0.
- Commit, wr_commit=1:
  - msg_valid=0 → swap: toggle bank_sel, msg_len ← wr_len, msg_sum ← fill_sum, msg_valid←1, fill_sum←0.
  - msg_valid=1 and pending=0 → pending←1 and latch wr_len. The write FSM stalls in IDLE (wr_rdy withheld) until the swap.
  - pending=1 → commit ignored, overrun pulses, latched length kept.
- Release, rd_release=1:
  - pending=1 → swap using the latched length; msg_valid stays 1; pending←0.
  - otherwise → msg_valid←0.
- Simultaneous wr_commit and rd_release while msg_valid=1, pending=0: swap immediately; msg_valid stays 1.
- rd_release while msg_valid=0: ignored.
- A write accepted in the same cycle as wr_commit belongs to the committed message.
- A read in flight at a swap completes from the bank sampled at request time.
- Reset values: wr_rdy=0, rd_rdy=0, data_o=0, msg_valid=0, msg_len=0, msg_sum=0, overrun=0; bank_sel=0, pending=0, fill_sum=0. Memory contents are not reset.
- Reset mid-transaction aborts the transaction with no acknowledge.

## Timing
- Write: wr_rq sampled high at edge T. Memory is updated at T. wr_rdy is high in cycle T+1. The earliest next acceptance is edge T+2.
- Read: rd_rq sampled at edge T. rd_rdy and data_o are valid in cycle T+RD_LAT.
- Commit/release: flag, length, sum and bank_sel updates are visible in the cycle after the pulse.
- A stalled write is accepted at the first edge after the swap.
- Throughput: one write per 2 cycles; one read per RD_LAT+1 cycles.

## Configuration
- MSG_BUF_CHECKSUM_EN defined: fill_sum XORs every accepted in-range write; msg_sum reports the checksum of the drain-bank message.
- MSG_BUF_CHECKSUM_EN undefined: no accumulator logic; msg_sum is tied to 0.

## Test plan
- Basic message: reset, write 0x11,0x22,0x33 at addresses 0..2, commit with len 3. Expect msg_valid=1, msg_len=3, msg_sum=0x00 with the macro on. Reads of 0..2 return 0x11,0x22,0x33, each rd_rdy RD_LAT cycles after rd_rq.
- Back-pressure:
  - commit a message, then commit a second (len 5) without release → pending; the next wr_rq gets no wr_rdy;
  - rd_release → msg_len=5 next cycle, msg_valid stays 1, the stalled write is acknowledged;
  - a third commit while pending → one overrun pulse.
- Simultaneous commit and release with msg_valid=1 → bank swap, msg_valid continuous, new msg_len.
- Out-of-range address 0x0100 with DEPTH=256: the write is acknowledged but memory and sum are unchanged; the read returns 0x00.
- Reset mid-operation: assert rst_l=0 mid-read with RD_LAT=3 → no rd_rdy, all outputs 0, bank_sel=0; operation resumes after release.
- With RD_LAT=4, DATA_W=16, macro undefined: msg_sum stays 0 and read latency is exactly 4 cycles.
